// File: rtl/contact_bounce_emulator_if.sv
// Request/response bundle between a bounce-emulator client and the emulator.
// Combinational wires only; the master issues start/target_level and receives the emulated contact plus status.
interface contact_bounce_emulator_if;
  logic start;
  logic target_level;
  logic bounce_out;
  logic busy;
  logic done;

  modport master (output start, target_level, input bounce_out, busy, done);
  modport slave  (input start, target_level, output bounce_out, busy, done);
endinterface

// File: rtl/contact_bounce_emulator.sv
// Contact-bounce stimulus source: target edge, 2*BOUNCE_PAIRS spaced toggles, settle hold, done pulse; start ignored while busy.
// Gaps are MIN_GAP + (lfsr & GAP_MASK) when CONTACT_BOUNCE_EMULATOR_RANDOM_EN is defined, otherwise exactly MIN_GAP.
module contact_bounce_emulator #(
  parameter int unsigned BOUNCE_PAIRS  = 3,
  parameter int unsigned MIN_GAP       = 16,
  parameter logic [15:0] GAP_MASK      = 16'h00FF,
  parameter int unsigned SETTLE_CYCLES = 20000,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input logic                        clk,
  input logic                        as_reset_n,
  contact_bounce_emulator_if.slave   bus
);

`ifdef CONTACT_BOUNCE_EMULATOR_RANDOM_EN
  localparam bit RANDOM_EN = 1'b1;
`else
  localparam bit RANDOM_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

  localparam logic [15:0] SEED_NZ      = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] EFF_MASK     = RANDOM_EN ? GAP_MASK : 16'h0000;
  localparam logic [15:0] MIN_GAP_W    = 16'(MIN_GAP);
  localparam logic [8:0]  TOGGLES_INIT = 9'(2 * BOUNCE_PAIRS);
  localparam logic [19:0] SETTLE_W     = 20'(SETTLE_CYCLES);

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] gap_val;
  logic [8:0]  toggles_q, toggles_d;
  logic [19:0] settle_q, settle_d;
  logic        bounce_q, bounce_d;
  logic        done_q, done_d;

  // Fibonacci x^16+x^14+x^13+x^11+1; runs in every state, so the gap sequence depends on request timing.
  assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign gap_val = MIN_GAP_W + (lfsr_q & EFF_MASK);

  always_comb begin
    state_d   = state_q;
    bounce_d  = bounce_q;
    done_d    = 1'b0;
    gap_d     = gap_q;
    toggles_d = toggles_q;
    settle_d  = settle_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.target_level != bounce_q) begin
            bounce_d  = bus.target_level;
            toggles_d = TOGGLES_INIT;
            if (BOUNCE_PAIRS == 0) begin
              settle_d = SETTLE_W;
              state_d  = SETTLE;
            end else begin
              gap_d   = gap_val;
              state_d = BOUNCE;
            end
          end else begin
            done_d = 1'b1;
          end
        end
      end
      BOUNCE: begin
        // A counter loaded with G expires on the G-th edge after loading.
        if (gap_q == 16'd1) begin
          bounce_d  = ~bounce_q;
          toggles_d = toggles_q - 9'd1;
          if (toggles_q == 9'd1) begin
            settle_d = SETTLE_W;
            state_d  = SETTLE;
          end else begin
            gap_d = gap_val;
          end
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      SETTLE: begin
        if (settle_q == 20'd1) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          settle_d = settle_q - 20'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge as_reset_n) begin
    if (!as_reset_n) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED_NZ;
      gap_q     <= '0;
      toggles_q <= '0;
      settle_q  <= '0;
      bounce_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      gap_q     <= gap_d;
      toggles_q <= toggles_d;
      settle_q  <= settle_d;
      bounce_q  <= bounce_d;
      done_q    <= done_d;
    end
  end

  assign bus.bounce_out = bounce_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;

endmodule

// File: tb/tb_contact_bounce_emulator.sv
// Bench for contact_bounce_emulator: three instances (two pairs, zero pairs, long random run) against a queue-based event model.
// Stimulus pushes expected edges/done pulses; a negedge monitor pops and checks timing, level, busy and a debounced view.
module tb_contact_bounce_emulator;

`ifdef CONTACT_BOUNCE_EMULATOR_RANDOM_EN
  localparam int SPREAD   = 255;
  localparam int SETTLE_C = 300;
  localparam int DEBN     = 280;
  localparam int NREQ     = 120;
`else
  localparam int SPREAD   = 0;
  localparam int SETTLE_C = 40;
  localparam int DEBN     = 24;
  localparam int NREQ     = 200;
`endif

  typedef struct {
    bit is_done;
    bit lvl;
    int abs_t;   // >= 0: absolute cycle; < 0: relative to previous event of this instance
    int dmin;
    int dmax;
  } evt_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic st_r [3];
  logic tl_r [3];
  logic bo [3];
  logic by [3];
  logic dn [3];

  evt_t evq [3][$];
  int   last_evt [3];
  bit   busy_act [3];
  int   busy_from [3];
  bit   mlvl [3];
  bit   prev_bo [3];
  int   mg [3];
  int   pairs [3];
  int   stl [3];
  int   deb_exp = 0;

  contact_bounce_emulator_if ifa ();
  contact_bounce_emulator_if ifb ();
  contact_bounce_emulator_if ifc ();

  assign ifa.start = st_r[0];  assign ifa.target_level = tl_r[0];
  assign ifb.start = st_r[1];  assign ifb.target_level = tl_r[1];
  assign ifc.start = st_r[2];  assign ifc.target_level = tl_r[2];
  assign bo[0] = ifa.bounce_out;  assign by[0] = ifa.busy;  assign dn[0] = ifa.done;
  assign bo[1] = ifb.bounce_out;  assign by[1] = ifb.busy;  assign dn[1] = ifb.done;
  assign bo[2] = ifc.bounce_out;  assign by[2] = ifc.busy;  assign dn[2] = ifc.done;

  contact_bounce_emulator #(.BOUNCE_PAIRS(2), .MIN_GAP(4), .GAP_MASK(16'h00FF), .SETTLE_CYCLES(10))
    u_a (.clk(clk), .as_reset_n(rst_n), .bus(ifa));
  contact_bounce_emulator #(.BOUNCE_PAIRS(0), .MIN_GAP(4), .GAP_MASK(16'h00FF), .SETTLE_CYCLES(10))
    u_b (.clk(clk), .as_reset_n(rst_n), .bus(ifb));
  contact_bounce_emulator #(.BOUNCE_PAIRS(1), .MIN_GAP(16), .GAP_MASK(16'h00FF), .SETTLE_CYCLES(SETTLE_C))
    u_c (.clk(clk), .as_reset_n(rst_n), .bus(ifc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference debouncer: output follows input once it has been stable for DEBN cycles.
  int   deb_cnt;
  logic deb_out;
  int   deb_edges;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt <= 0; deb_out <= 1'b0; deb_edges <= 0;
    end else if (bo[2] != deb_out) begin
      if (deb_cnt == DEBN - 1) begin
        deb_out <= bo[2]; deb_cnt <= 0; deb_edges <= deb_edges + 1;
      end else begin
        deb_cnt <= deb_cnt + 1;
      end
    end else begin
      deb_cnt <= 0;
    end
  end

  function automatic evt_t mk(input bit d, input bit l, input int t, input int lo, input int hi);
    evt_t e;
    e.is_done = d; e.lvl = l; e.abs_t = t; e.dmin = lo; e.dmax = hi;
    return e;
  endfunction

  task automatic chk(input string nm, input int d, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d: got %0d want %0d", nm, d, cyc, got, want);
    end
  endtask

  task automatic chk_rng(input string nm, input int d, input int got, input int lo, input int hi);
    total++;
    if (got < lo || got > hi) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d: got %0d want %0d..%0d", nm, d, cyc, got, lo, hi);
    end
  endtask

  task automatic check_evt(input int d, input bit is_done, input bit lvl);
    evt_t e;
    if (evq[d].size() == 0) begin
      chk(is_done ? "unexpected_done" : "unexpected_edge", d, 1, 0);
    end else begin
      e = evq[d].pop_front();
      chk("event_kind", d, int'(is_done), int'(e.is_done));
      if (!is_done) chk("edge_level", d, int'(lvl), int'(e.lvl));
      if (e.abs_t >= 0) chk("event_time", d, cyc, e.abs_t);
      else chk_rng(is_done ? "settle_span" : "edge_gap", d, cyc - last_evt[d], e.dmin, e.dmax);
      last_evt[d] = cyc;
      if (is_done) busy_act[d] = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (!rst_n) begin
          prev_bo[d] = 1'b0;
        end else begin
          if (bo[d] != prev_bo[d]) begin
            prev_bo[d] = bo[d];
            check_evt(d, 1'b0, bo[d]);
          end
          if (dn[d]) check_evt(d, 1'b1, 1'b0);
          chk("busy", d, int'(by[d]), int'(busy_act[d] && cyc >= busy_from[d]));
        end
      end
    end
  end

  // Called in the low clock phase; the next rising edge is E0.
  task automatic push_req(input int d, input bit lvl, output int e0);
    e0 = cyc + 1;
    if (lvl == mlvl[d]) begin
      evq[d].push_back(mk(1'b1, 1'b0, e0, 0, 0));
    end else begin
      evq[d].push_back(mk(1'b0, lvl, e0, 0, 0));
      for (int i = 0; i < 2 * pairs[d]; i++)
        evq[d].push_back(mk(1'b0, (i % 2 == 0) ? !lvl : lvl, -1, mg[d], mg[d] + SPREAD));
      evq[d].push_back(mk(1'b1, 1'b0, -1, stl[d], stl[d]));
      busy_act[d]  = 1'b1;
      busy_from[d] = e0;
      mlvl[d]      = lvl;
      if (d == 2) deb_exp++;
    end
    st_r[d] = 1'b1;
    tl_r[d] = lvl;
    @(posedge clk);
    #1;
    st_r[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((evq[d].size() != 0 || busy_act[d]) && n < budget);
    chk("request_timeout", d, int'(evq[d].size() != 0 || busy_act[d]), 0);
  endtask

  task automatic stray_start(input int d, input int at, input bit lvl);
    while (cyc < at) @(negedge clk);
    st_r[d] = 1'b1;
    tl_r[d] = lvl;
    @(posedge clk);
    #1;
    st_r[d] = 1'b0;
  endtask

  initial begin
    #15_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0;
    bit lvl;
    bit tgt;
    mg    = '{4, 4, 16};
    pairs = '{2, 0, 1};
    stl   = '{10, 10, SETTLE_C};
    for (int d = 0; d < 3; d++) begin
      st_r[d] = 1'b0; tl_r[d] = 1'b0; busy_act[d] = 1'b0; busy_from[d] = 0;
      mlvl[d] = 1'b0; prev_bo[d] = 1'b0; last_evt[d] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_bounce_out", d, int'(bo[d]), 0);
      chk("reset_busy", d, int'(by[d]), 0);
      chk("reset_done", d, int'(dn[d]), 0);
    end

    // Equal level straight after reset, then a clean rise and fall.
    push_req(0, 1'b0, e0);  wait_idle(0, 2000);
    push_req(0, 1'b1, e0);  wait_idle(0, 2000);
    chk("final_level_rise", 0, int'(bo[0]), 1);
    push_req(0, 1'b0, e0);  wait_idle(0, 2000);
    chk("final_level_fall", 0, int'(bo[0]), 0);

    // Start with the opposite level at E6 must leave the waveform alone.
    push_req(0, 1'b1, e0);
    stray_start(0, e0 + 5, 1'b0);
    wait_idle(0, 2000);
    chk("final_level_ignored", 0, int'(bo[0]), 1);

    // Asynchronous reset between E5 and E6.
    push_req(0, 1'b0, e0);  wait_idle(0, 2000);
    push_req(0, 1'b1, e0);
    while (cyc < e0 + 5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_bounce_out", 0, int'(bo[0]), 0);
    chk("abort_busy", 0, int'(by[0]), 0);
    chk("abort_done", 0, int'(dn[0]), 0);
    for (int d = 0; d < 3; d++) begin
      evq[d].delete();
      busy_act[d] = 1'b0;
      mlvl[d] = 1'b0;
    end
    deb_exp = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    push_req(0, 1'b1, e0);  wait_idle(0, 2000);
    chk("final_level_after_reset", 0, int'(bo[0]), 1);

    // Zero pairs, second request at the edge after done.
    push_req(1, 1'b1, e0);  wait_idle(1, 2000);
    push_req(1, 1'b0, e0);  wait_idle(1, 2000);
    chk("final_level_zero_pairs", 1, int'(bo[1]), 0);

    // Long randomized run with stray starts and the debounced view.
    lvl = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        tgt = mlvl[2];
      end else begin
        lvl = !lvl;
        tgt = lvl;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push_req(2, tgt, e0);
      if (busy_act[2]) stray_start(2, e0 + int'($urandom_range(1, 10)), 1'($urandom_range(0, 1)));
      wait_idle(2, 2000);
      chk("rand_final_level", 2, int'(bo[2]), int'(tgt));
      chk("debounced_edges", 2, deb_edges, deb_exp);
      chk("debounced_level", 2, int'(deb_out), int'(tgt));
    end

    repeat (4) @(negedge clk);
    for (int d = 0; d < 3; d++) chk("leftover_events", d, evq[d].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/contact_bounce_emulator.md
# contact_bounce_emulator

- Synthesizable stimulus source that drives the input of the team's input-debouncer blocks.
- On a start request with a target level, it:
  - drives the output to the target level,
  - produces a configurable burst of contact-bounce toggles with pseudo-random spacing,
  - holds the settled level for a fixed time, then reports completion.
- Used on-board and in simulation to exercise the debouncer from the transmitting side.

## Interface
- `BOUNCE_PAIRS`, 3: number of extra back-and-forth toggle pairs after the first transition; 0..255.
- `MIN_GAP`, 16: minimum cycles between consecutive output edges; 1..(65535−`GAP_MASK`).
- `GAP_MASK`, 16'h00FF: mask applied to the LFSR value and added to `MIN_GAP` (random build only).
- `SETTLE_CYCLES`, 20000: cycles the final level is held before `done`; 1..2^20−1.
- `SEED`, 16'hACE1: LFSR reset value. Zero is replaced by 16'h0001.
- `clk`  input  1  system clock, all logic rising-edge.
- `as_reset_n`  input  1  reset, asynchronous, active-low.
- `start`  input  1  request. Sampled only in IDLE.
- `target_level`  input  1  requested final level, sampled with `start`.
- `bounce_out`  output  1  emulated contact signal, registered. Feeds the debouncer input.
- `busy`  output  1  high while in BOUNCE or SETTLE.
- `done`  output  1  one-cycle pulse when a request completes.

## Operation
- **States:** IDLE, BOUNCE, SETTLE. Reset: IDLE, `bounce_out`=0, `busy`=0, `done`=0, LFSR=`SEED`, all counters 0.
- **LFSR:** 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1. Free-running, advances every cycle in every state, never zero.
- **Gap value:** G = `MIN_GAP` + (lfsr & `GAP_MASK`), sampled at each edge where a gap is loaded. 16-bit unsigned, no overflow within the legal parameter range.
- **IDLE, `start`=1, `target_level` ≠ `bounce_out`:**
  - `bounce_out` ← `target_level`, `busy` ← 1.
  - Toggles-left counter ← 2·`BOUNCE_PAIRS`.
  - If `BOUNCE_PAIRS`=0, go to SETTLE; otherwise load the gap counter with G and go to BOUNCE.
- **IDLE, `start`=1, `target_level` = `bounce_out`:**
  - `done` ← 1 for one cycle; `busy` stays 0; `bounce_out` unchanged; remain in IDLE.
- **BOUNCE:**
  - On gap expiry, toggle `bounce_out` and decrement toggles-left.
  - If toggles-left becomes 0, load the settle counter and go to SETTLE; otherwise reload the gap with a fresh G.
  - Toggle count is even, so the final level always equals the target.
- **SETTLE:** on settle-counter expiry: `done` ← 1, `busy` ← 0, go to IDLE.
- `start` while `busy`=1 is ignored, with no queuing. `target_level` is ignored outside the start cycle.
- **Reset mid-operation:** immediate return to the reset values. `bounce_out` goes to 0 asynchronously; no `done` is issued for the aborted request.

## Timing
- Edge E0 = the clock edge that samples `start`=1 in IDLE.
- At E0, `bounce_out` = target and `busy` = 1, both visible in the following cycle.
- Each subsequent toggle occurs exactly G cycles after the previous output edge.
- `done` is asserted at the edge `SETTLE_CYCLES` cycles after the last output edge, and `busy` falls at that same edge.
- **Fixed-gap build** (`GAP_MASK` ignored), total request time:
  - `BOUNCE_PAIRS`>0: E0 + 2·`BOUNCE_PAIRS`·`MIN_GAP` + `SETTLE_CYCLES`.
  - `BOUNCE_PAIRS`=0: E0 + `SETTLE_CYCLES`.
- **Equal-level request:** `done` asserted at E0, visible one cycle, no other activity.
- **Back-to-back:** the earliest accepted new `start` is at the edge after the one that asserted `done`.

## Configuration
- Macro: `CONTACT_BOUNCE_EMULATOR_RANDOM_EN`.
- **Defined:** gaps are `MIN_GAP` + (lfsr & `GAP_MASK`), as above.
- **Undefined:**
  - Every gap is exactly `MIN_GAP` and `GAP_MASK` has no effect.
  - The LFSR still exists and runs, so reset behaviour is identical.
  - Timing is fully deterministic.

## Test plan
1. **Basic rise** (macro undefined, `MIN_GAP`=4, `BOUNCE_PAIRS`=2, `SETTLE_CYCLES`=10).
   - Stimulus: reset, then `start`=1 with `target_level`=1 at E0.
   - Expect `bounce_out` 1@E0, 0@E4, 1@E8, 0@E12, 1@E16.
   - Expect a single `done` pulse at E26, and `busy` high E0..E26.
2. **Equal level.**
   - Stimulus: directly after reset, `start` with `target_level`=0.
   - Expect one `done` pulse at E0, `busy` never high, `bounce_out` stays 0.
3. **Ignored start.**
   - Stimulus: during test 1, assert `start` with `target_level`=0 at E6.
   - Expect the waveform identical to test 1 and exactly one `done`.
4. **Zero pairs** (`BOUNCE_PAIRS`=0).
   - Stimulus: `start` with `target_level`=1 at E0, then `target_level`=0 at the edge after `done`.
   - Expect `bounce_out` to rise at E0 with `done` at E10.
   - Expect the second request to fall cleanly with `done` 10 cycles after its start.
5. **Reset mid-BOUNCE.**
   - Stimulus: drop `as_reset_n` asynchronously between E5 and E6 of test 1.
   - Expect `bounce_out`, `busy` and `done` all 0 immediately.
   - After release, a new `start` reproduces the test 1 waveform.
6. **Random gaps** (macro defined, `MIN_GAP`=16, `GAP_MASK`=16'h00FF).
   - Stimulus: 200 alternating requests.
   - Every edge spacing must be in 16..271 and the final level must equal the target.
   - Feed `bounce_out` into the debouncer; its output must show exactly one edge per request.
